// File: rtl/fifo_rd_drainer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_drainer
// Purpose  : FIFO read master with skid buffer, valid/ready output and flush.
//            Optional beat counter enabled by FIFO_RD_DRAINER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_drainer #(
    parameter int FIFO_WIDTH = 16,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  empty,
    input  logic                  underflow,
    input  logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  flush_done,
    output logic                  proto_err
`ifdef FIFO_RD_DRAINER_STATS_EN
    ,
    output logic [15:0]           beat_cnt
`endif
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                  state;
    logic [OW-1:0]           occ;
    logic                    infl;
    logic [AW-1:0]           head;
    logic [AW-1:0]           tail;
    logic [FIFO_WIDTH-1:0]   mem [BUF_DEPTH];

    logic                    pop;
    logic                    push;
    logic                    flush_start;
    logic                    flush_exit;
    logic [OW:0]             committed;

    assign pop         = m_valid && m_ready;
    assign push        = infl && (state != S_FLUSH);
    assign flush_start = flush && (state != S_FLUSH);
    assign flush_exit  = (state == S_FLUSH) && !flush && empty && !infl;

    // Slots already spoken for once this cycle's pop leaves.
    assign committed = {1'b0, occ} + (OW+1)'(infl) - (OW+1)'(pop);

    always_comb begin
        rd_en = 1'b0;
        case (state)
            S_RUN:   rd_en = !empty && (committed < (OW+1)'(BUF_DEPTH));
            S_FLUSH: rd_en = !empty;
            default: rd_en = 1'b0;
        endcase
    end

    assign m_valid    = (occ != '0) && (state != S_FLUSH);
    assign m_data     = mem[head];
    assign flush_done = flush_exit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            occ       <= '0;
            infl      <= 1'b0;
            head      <= '0;
            tail      <= '0;
            proto_err <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            infl      <= rd_en;
            proto_err <= proto_err | underflow;

            case (state)
                S_IDLE: begin
                    if (flush)       state <= S_FLUSH;
                    else if (enable) state <= S_RUN;
                end
                S_RUN: begin
                    if (flush)        state <= S_FLUSH;
                    else if (!enable) state <= S_IDLE;
                end
                S_FLUSH: begin
                    if (flush_exit) state <= enable ? S_RUN : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Entering flush discards everything buffered, including any word landing now.
            if (flush_start) begin
                occ  <= '0;
                head <= '0;
                tail <= '0;
            end else begin
                if (push) begin
                    mem[tail] <= data_out;
                    tail      <= tail + AW'(1);
                end
                if (pop) begin
                    head <= head + AW'(1);
                end
                occ <= occ + OW'(push) - OW'(pop);
            end
        end
    end

`ifdef FIFO_RD_DRAINER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= beat_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire
